// File: rtl/writeback_unit.sv
// writeback_unit: merges load responses and ALU results onto the single
// register-file write port, buffers ALU results that lose arbitration,
// tracks outstanding load destinations and exports a per-register hazard mask.
module writeback_unit #(
  parameter int LD_DEPTH  = 4,
  parameter int ALU_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [2:0]  alu_dest,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue_valid,
  input  logic [2:0]  ld_issue_dest,
  output logic        ld_issue_ready,
  input  logic        ld_resp_valid,
  input  logic [15:0] ld_resp_data,
  output logic        reg_write_en,
  output logic [2:0]  reg_write_dest,
  output logic [15:0] reg_write_data,
  output logic [7:0]  hazard_mask,
  output logic        ld_err
);

  localparam int LD_AW  = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int LD_CW  = $clog2(LD_DEPTH + 1);
  localparam int ALU_AW = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int ALU_CW = $clog2(ALU_DEPTH + 1);

  // Load-tag FIFO state
  logic [2:0]        tag_mem    [LD_DEPTH];
  logic              tag_vld    [LD_DEPTH];
  logic [7:0]        tag_onehot [LD_DEPTH];
  logic [LD_AW-1:0]  tag_wr_ptr;
  logic [LD_AW-1:0]  tag_rd_ptr;
  logic [LD_CW-1:0]  tag_count;

  // ALU skid FIFO state
  logic [2:0]        alu_dest_mem [ALU_DEPTH];
  logic [15:0]       alu_data_mem [ALU_DEPTH];
  logic              alu_vld      [ALU_DEPTH];
  logic [7:0]        alu_onehot   [ALU_DEPTH];
  logic [ALU_AW-1:0] alu_wr_ptr;
  logic [ALU_AW-1:0] alu_rd_ptr;
  logic [ALU_CW-1:0] alu_count;

  // Arbitration signals
  logic tag_empty;
  logic alu_fifo_empty;
  logic tag_push;
  logic resp_pop;
  logic alu_accept;
  logic fifo_win;
  logic direct_win;
  logic alu_push;

  // Readiness is decided on registered counts only, so a same-cycle pop never
  // opens room.
  assign ld_issue_ready = (tag_count < LD_CW'(LD_DEPTH));
  assign alu_ready      = (alu_count < ALU_CW'(ALU_DEPTH));

  assign tag_empty      = (tag_count == '0);
  assign alu_fifo_empty = (alu_count == '0);
  assign tag_push       = ld_issue_valid && ld_issue_ready;
  // A response only counts when a tag is outstanding; orphan responses are
  // dropped and flagged through ld_err.
  assign resp_pop       = ld_resp_valid && !tag_empty;
  assign alu_accept     = alu_valid && alu_ready;
  assign fifo_win       = !resp_pop && !alu_fifo_empty;
  assign direct_win     = !resp_pop && alu_fifo_empty && alu_accept;
  assign alu_push       = alu_accept && !direct_win;

  genvar gi;
  generate
    for (gi = 0; gi < LD_DEPTH; gi++) begin : g_tag
      // Tag entry captures the issuing dest and stays valid until its response pops it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_mem[gi] <= '0;
          tag_vld[gi] <= 1'b0;
        end else if (tag_push && (tag_wr_ptr == LD_AW'(gi))) begin
          tag_mem[gi] <= ld_issue_dest;
          tag_vld[gi] <= 1'b1;
        end else if (resp_pop && (tag_rd_ptr == LD_AW'(gi))) begin
          tag_vld[gi] <= 1'b0;
        end
      end
      assign tag_onehot[gi] = tag_vld[gi] ? (8'b1 << tag_mem[gi]) : 8'b0;
    end

    for (gi = 0; gi < ALU_DEPTH; gi++) begin : g_alu
      // ALU entry holds a result that lost the port until its turn at the head.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          alu_dest_mem[gi] <= '0;
          alu_data_mem[gi] <= '0;
          alu_vld[gi]      <= 1'b0;
        end else if (alu_push && (alu_wr_ptr == ALU_AW'(gi))) begin
          alu_dest_mem[gi] <= alu_dest;
          alu_data_mem[gi] <= alu_data;
          alu_vld[gi]      <= 1'b1;
        end else if (fifo_win && (alu_rd_ptr == ALU_AW'(gi))) begin
          alu_vld[gi]      <= 1'b0;
        end
      end
      assign alu_onehot[gi] = alu_vld[gi] ? (8'b1 << alu_dest_mem[gi]) : 8'b0;
    end
  endgenerate

  // Tag FIFO pointers and occupancy (depth is a power of two, pointers wrap naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (resp_pop) tag_rd_ptr <= tag_rd_ptr + 1'b1;
      tag_count <= tag_count + LD_CW'(tag_push) - LD_CW'(resp_pop);
    end
  end

  // ALU FIFO pointers and occupancy; explicit wrap allows any depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_count  <= '0;
    end else begin
      if (alu_push)
        alu_wr_ptr <= (alu_wr_ptr == ALU_AW'(ALU_DEPTH - 1)) ? '0 : alu_wr_ptr + 1'b1;
      if (fifo_win)
        alu_rd_ptr <= (alu_rd_ptr == ALU_AW'(ALU_DEPTH - 1)) ? '0 : alu_rd_ptr + 1'b1;
      alu_count <= alu_count + ALU_CW'(alu_push) - ALU_CW'(fifo_win);
    end
  end

  // Output register: load the arbitration winner; hold dest/data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else if (resp_pop) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= tag_mem[tag_rd_ptr];
      reg_write_data <= ld_resp_data;
    end else if (fifo_win) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= alu_dest_mem[alu_rd_ptr];
      reg_write_data <= alu_data_mem[alu_rd_ptr];
    end else if (direct_win) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= alu_dest;
      reg_write_data <= alu_data;
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

  // Sticky error: a response arrived while no load was outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else if (ld_resp_valid && tag_empty) begin
      ld_err <= 1'b1;
    end
  end

  // Hazard mask: every pending write, including the one the file takes next edge.
  always_comb begin
    hazard_mask = reg_write_en ? (8'b1 << reg_write_dest) : 8'b0;
    for (int i = 0; i < LD_DEPTH; i++) hazard_mask = hazard_mask | tag_onehot[i];
    for (int i = 0; i < ALU_DEPTH; i++) hazard_mask = hazard_mask | alu_onehot[i];
  end

endmodule
